// File: rtl/tia_pkg.sv
// Shared TIA types: beam FSM states, default display timing, beam coordinate type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tia_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2
    } tia_state_e;

    // Beam coordinate shared by the sequencer, the colour mux and the register block.
    typedef logic [8:0] beam_coord_t;

    localparam int TIA_H_TOTAL     = 456;
    localparam int TIA_H_VISIBLE   = 320;
    localparam int TIA_V_TOTAL     = 262;
    localparam int TIA_V_VISIBLE   = 240;
    localparam int TIA_V_TOP       = 24;
    localparam int TIA_V_BOTTOM    = 226;
    localparam int TIA_PACE_CYCLES = 8;

    // Advance a beam counter, wrapping to zero on its last value.
    function automatic beam_coord_t coord_step(input beam_coord_t c, input beam_coord_t last);
        return (c == last) ? '0 : c + 9'd1;
    endfunction

endpackage

// File: rtl/tia_beam_sequencer_if.sv
// Beam sequencer bundle: CPU sync requests, LCD busy/strobe, beam position and status.
// Latency: n/a (wiring only).
// Backpressure: lcd_busy from the LCD write engine holds the beam in place.
// master = sequencer side, slave = CPU/LCD/colour-mux side.
interface tia_beam_sequencer_if;
    import tia_pkg::*;

    logic        wsync_req;
    logic        vsync_req;
    logic        lcd_busy;
    logic        pix_clk;
    logic        reset_cursor;
    beam_coord_t xpos;
    beam_coord_t ypos;
    logic        draw_en;
    logic        fill_black;
    logic        stall_cpu;
    logic        line_done;
    logic        frame_done;

    modport master (
        input  wsync_req, vsync_req, lcd_busy,
        output pix_clk, reset_cursor, xpos, ypos, draw_en, fill_black,
               stall_cpu, line_done, frame_done
    );

    modport slave (
        output wsync_req, vsync_req, lcd_busy,
        input  pix_clk, reset_cursor, xpos, ypos, draw_en, fill_black,
               stall_cpu, line_done, frame_done
    );

endinterface

// File: rtl/tia_pace_timer.sv
// Pace down-counter: idles the beam for PACE_CYCLES cycles after every step.
// Latency: done is high in the PACE_CYCLES-th cycle after load.
// Backpressure: none; clr aborts a count in progress.
// Ports: clk_i/resetn clock and async active-low reset; load starts a count,
// clr empties the counter, done flags the last gap cycle.
module tia_pace_timer
    import tia_pkg::*;
#(
    parameter int PACE_CYCLES = TIA_PACE_CYCLES
) (
    input  logic clk_i,
    input  logic resetn,
    input  logic load,
    input  logic clr,
    output logic done
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (load) begin
            cnt_q <= 8'(PACE_CYCLES);
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    // Load lands the count on the first gap cycle, so "1" marks the last one.
    assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/tia_beam_sequencer.sv
// TIA beam sequencer: owns the beam counters, paces pixel strobes, applies VSYNC/WSYNC.
// Latency: one beam step per 1+PACE_CYCLES cycles; pix_clk/line_done/frame_done fire in the step cycle.
// Backpressure: lcd_busy high holds the step (no strobe, beam frozen) until it drops.
// Ports: clk_i, resetn (async active-low); bus (tia_beam_sequencer_if.master) carries
// wsync_req/vsync_req/lcd_busy in and pix_clk, reset_cursor, xpos, ypos, draw_en,
// fill_black, stall_cpu, line_done, frame_done out.
// Option: define TIA_VSYNC_AUTO_EN to re-home the LCD cursor on a natural frame wrap.
module tia_beam_sequencer
    import tia_pkg::*;
#(
    parameter int H_TOTAL     = TIA_H_TOTAL,
    parameter int H_VISIBLE   = TIA_H_VISIBLE,
    parameter int V_TOTAL     = TIA_V_TOTAL,
    parameter int V_VISIBLE   = TIA_V_VISIBLE,
    parameter int V_TOP       = TIA_V_TOP,
    parameter int V_BOTTOM    = TIA_V_BOTTOM,
    parameter int PACE_CYCLES = TIA_PACE_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  resetn,
    tia_beam_sequencer_if.master  bus
);

    localparam beam_coord_t H_LAST     = beam_coord_t'(H_TOTAL - 1);
    localparam beam_coord_t V_LAST     = beam_coord_t'(V_TOTAL - 1);
    localparam beam_coord_t H_VIS_LAST = beam_coord_t'(H_VISIBLE - 1);
    localparam beam_coord_t H_VIS      = beam_coord_t'(H_VISIBLE);
    localparam beam_coord_t V_VIS      = beam_coord_t'(V_VISIBLE);
    localparam beam_coord_t V_TOP_C    = beam_coord_t'(V_TOP);
    localparam beam_coord_t V_BOT_C    = beam_coord_t'(V_BOTTOM);

    tia_state_e  state_q, state_d;
    beam_coord_t xpos_q, xpos_d;
    beam_coord_t ypos_q, ypos_d;
    logic        stall_q, stall_d;
    logic        armed_q;
    logic        pix_c, line_c, frame_c;
    logic        pace_load, pace_clr, pace_done;
    logic        draw_en;

    // armed_q keeps reset_cursor low while resetn is asserted; the first
    // S_SYNC after reset is therefore stretched by one cycle so the cursor
    // pulse is still visible once reset is released.
    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_SYNC;
            xpos_q  <= '0;
            ypos_q  <= '0;
            stall_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            stall_q <= stall_d;
            armed_q <= 1'b1;
        end
    end

    assign draw_en = (xpos_q < H_VIS) && (ypos_q < V_VIS);

    always_comb begin
        state_d   = state_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        stall_d   = stall_q;
        pix_c     = 1'b0;
        line_c    = 1'b0;
        frame_c   = 1'b0;
        pace_load = 1'b0;
        pace_clr  = 1'b0;

        if (bus.wsync_req) begin
            stall_d = 1'b1;
        end

        unique case (state_q)
            S_SYNC: begin
                xpos_d  = '0;
                ypos_d  = '0;
                stall_d = 1'b0;
                if (armed_q) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (!bus.lcd_busy) begin
                    pix_c     = draw_en;
                    xpos_d    = coord_step(xpos_q, H_LAST);
                    pace_load = 1'b1;
                    state_d   = S_GAP;
                    // Horizontal blank starts here; a WSYNC in the same cycle re-arms the stall.
                    if (xpos_q == H_VIS_LAST) begin
                        stall_d = bus.wsync_req;
                    end
                    if (xpos_q == H_LAST) begin
                        line_c = 1'b1;
                        ypos_d = coord_step(ypos_q, V_LAST);
                        if (ypos_q == V_LAST) begin
                            frame_c = 1'b1;
`ifdef TIA_VSYNC_AUTO_EN
                            // Any VSYNC would have restarted the beam at line 0, so
                            // reaching the natural wrap means the frame had none.
                            state_d = S_SYNC;
`else
                            state_d = S_GAP;
`endif
                        end
                    end
                end
            end
            S_GAP: begin
                if (pace_done) begin
                    state_d = S_STEP;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        // VSYNC overrides everything: abort the gap/busy wait and home the beam now.
        if (bus.vsync_req) begin
            state_d   = S_SYNC;
            xpos_d    = '0;
            ypos_d    = '0;
            stall_d   = 1'b0;
            pix_c     = 1'b0;
            line_c    = 1'b0;
            frame_c   = 1'b0;
            pace_load = 1'b0;
            pace_clr  = 1'b1;
        end
    end

    tia_pace_timer #(
        .PACE_CYCLES (PACE_CYCLES)
    ) u_pace (
        .clk_i  (clk_i),
        .resetn (resetn),
        .load   (pace_load),
        .clr    (pace_clr),
        .done   (pace_done)
    );

    assign bus.pix_clk      = pix_c;
    assign bus.line_done    = line_c;
    assign bus.frame_done   = frame_c;
    assign bus.reset_cursor = (state_q == S_SYNC) && armed_q;
    assign bus.xpos         = xpos_q;
    assign bus.ypos         = ypos_q;
    assign bus.draw_en      = draw_en;
    assign bus.fill_black   = draw_en && ((ypos_q < V_TOP_C) || (ypos_q >= V_BOT_C));
    assign bus.stall_cpu    = stall_q;

endmodule

// File: tb/tb_tia_beam_sequencer.sv
// Bench for tia_beam_sequencer: scoreboard of expected strobe events plus directed checks.
// Latency: n/a.
// Backpressure: drives lcd_busy to hold the beam.
// Uses a short frame (20 lines) and PACE_CYCLES=2 so a whole frame fits a short run.
module tb_tia_beam_sequencer;
    import tia_pkg::*;

    localparam int HT   = 456;
    localparam int HV   = 320;
    localparam int VT   = 20;
    localparam int VV   = 16;
    localparam int VTOP = 2;
    localparam int VBOT = 12;
    localparam int PACE = 2;
    localparam int LINE_CYC = HT * (PACE + 1);

    localparam logic [2:0] EV_PIX    = 3'd1;
    localparam logic [2:0] EV_LINE   = 3'd2;
    localparam logic [2:0] EV_FRAME  = 3'd3;
    localparam logic [2:0] EV_CURSOR = 3'd4;

`ifdef TIA_VSYNC_AUTO_EN
    localparam logic AUTO_CURSOR = 1'b1;
`else
    localparam logic AUTO_CURSOR = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tia_beam_sequencer_if bus ();

    tia_beam_sequencer #(
        .H_TOTAL     (HT),
        .H_VISIBLE   (HV),
        .V_TOTAL     (VT),
        .V_VISIBLE   (VV),
        .V_TOP       (VTOP),
        .V_BOTTOM    (VBOT),
        .PACE_CYCLES (PACE)
    ) dut (
        .clk_i  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ev(input logic [2:0] kind, input int x, input int y);
        return {11'd0, kind, 9'(y), 9'(x)};
    endfunction

    task automatic observe(input logic [2:0] kind);
        logic [31:0] got;
        logic [31:0] want;
        got = {11'd0, kind, bus.ypos, bus.xpos};
        if (exp_q.size() == 0) want = '1;
        else                   want = exp_q.pop_front();
        check("event", got, want);
    endtask

    // Scoreboard: every strobe seen while enabled must match the head of exp_q.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pix_clk)      observe(EV_PIX);
            if (bus.line_done)    observe(EV_LINE);
            if (bus.frame_done)   observe(EV_FRAME);
            if (bus.reset_cursor) observe(EV_CURSOR);
        end
    end

    task automatic wait_drain(input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check(tag, exp_q.size(), 0);
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_x(input int x, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * LINE_CYC && !hit; i++) begin
            @(negedge clk);
            if (bus.xpos == 9'(x)) hit = 1'b1;
        end
        if (!hit) check(tag, 0, 1);
    endtask

    initial begin
        int last_t;
        int npix;
        int bad_x;
        bit hit;

        bus.wsync_req = 1'b0;
        bus.vsync_req = 1'b0;
        bus.lcd_busy  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pix",    bus.pix_clk, 0);
        check("rst_cursor", bus.reset_cursor, 0);
        check("rst_line",   bus.line_done, 0);
        check("rst_frame",  bus.frame_done, 0);
        check("rst_stall",  bus.stall_cpu, 0);
        check("rst_xpos",   bus.xpos, 0);
        check("rst_ypos",   bus.ypos, 0);

        // Release: one cursor pulse then strobes at x=0,1,2 spaced 1+PACE cycles
        @(posedge clk); #1;
        exp_q.push_back(ev(EV_CURSOR, 0, 0));
        for (int x = 0; x < 3; x++) exp_q.push_back(ev(EV_PIX, x, 0));
        mon_en = 1'b1;
        resetn = 1'b1;
        npix = 0;
        last_t = 0;
        for (int t = 0; t < 100 && npix < 3; t++) begin
            @(negedge clk);
            if (bus.pix_clk) begin
                if (npix == 0) begin
                    check("first_fill_black", bus.fill_black, 1);
                    check("first_draw_en", bus.draw_en, 1);
                end else begin
                    check("pix_period", t - last_t, PACE + 1);
                end
                last_t = t;
                npix++;
            end
        end
        if (npix < 3) check("startup_pix_count", npix, 3);
        wait_drain(50, "startup_drain");

        // Full picture line at y=5: 320 strobes, silent blank, line_done at 455
        hit = 1'b0;
        for (int i = 0; i < 6 * LINE_CYC && !hit; i++) begin
            @(negedge clk);
            if (bus.line_done && bus.ypos == 9'd4) hit = 1'b1;
        end
        if (!hit) check("wait_line4", 0, 1);
        @(posedge clk); #1;
        check("line5_draw_en", bus.draw_en, 1);
        check("line5_fill_black", bus.fill_black, 0);
        for (int x = 0; x < HV; x++) exp_q.push_back(ev(EV_PIX, x, 5));
        exp_q.push_back(ev(EV_LINE, HT - 1, 5));
        mon_en = 1'b1;
        wait_drain(LINE_CYC + 50, "line5_drain");
        @(posedge clk); #1;
        check("line5_next_x", bus.xpos, 0);
        check("line5_next_y", bus.ypos, 6);

        // WSYNC mid-line: stall until blank starts
        wait_x(100, "wait_x100");
        @(posedge clk); #1;
        bus.wsync_req = 1'b1;
        @(posedge clk); #1;
        bus.wsync_req = 1'b0;
        check("stall_set", bus.stall_cpu, 1);
        wait_x(HV - 1, "wait_x319");
        check("stall_hold", bus.stall_cpu, 1);
        wait_x(HV, "wait_x320");
        check("stall_clear", bus.stall_cpu, 0);

        // WSYNC held across the clearing step: set wins, repeat writes are harmless
        wait_x(HV - 1, "wait_x319b");
        @(posedge clk); #1;
        bus.wsync_req = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 4 * (PACE + 1) && !hit; i++) begin
            @(posedge clk); #1;
            if (bus.xpos != 9'(HV - 1)) hit = 1'b1;
        end
        bus.wsync_req = 1'b0;
        if (!hit) check("wait_x320b", 0, 1);
        check("stall_set_wins", bus.stall_cpu, 1);
        wait_x(HV - 1, "wait_x319c");
        check("stall_hold_next", bus.stall_cpu, 1);
        wait_x(HV, "wait_x320c");
        check("stall_clear_next", bus.stall_cpu, 0);

        // LCD busy: beam frozen, no strobes, strobe as soon as busy drops
        wait_x(10, "wait_x10");
        @(posedge clk); #1;
        bus.lcd_busy = 1'b1;
        npix = 0;
        bad_x = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.pix_clk) npix++;
            if (bus.xpos != 9'd10) bad_x++;
        end
        check("busy_pix_count", npix, 0);
        check("busy_x_moved", bad_x, 0);
        @(posedge clk); #1;
        bus.lcd_busy = 1'b0;
        @(negedge clk);
        check("busy_release_pix", bus.pix_clk, 1);
        check("busy_release_x", bus.xpos, 10);

        // VSYNC with WSYNC mid-gap: sync wins, beam homes at once
        wait_x(200, "wait_x200");
        @(posedge clk); #1;
        exp_q.push_back(ev(EV_CURSOR, 0, 0));
        exp_q.push_back(ev(EV_PIX, 0, 0));
        exp_q.push_back(ev(EV_PIX, 1, 0));
        mon_en = 1'b1;
        bus.vsync_req = 1'b1;
        bus.wsync_req = 1'b1;
        @(posedge clk); #1;
        bus.vsync_req = 1'b0;
        bus.wsync_req = 1'b0;
        check("vsync_cursor", bus.reset_cursor, 1);
        check("vsync_x", bus.xpos, 0);
        check("vsync_y", bus.ypos, 0);
        check("vsync_stall", bus.stall_cpu, 0);
        wait_drain(50, "vsync_drain");

        // Free-running frame: wrap at last line, cursor only with auto-sync
        hit = 1'b0;
        for (int i = 0; i < VT * LINE_CYC + 100 && !hit; i++) begin
            @(negedge clk);
            if (bus.frame_done) hit = 1'b1;
        end
        if (!hit) check("wait_frame", 0, 1);
        check("frame_x", bus.xpos, HT - 1);
        check("frame_y", bus.ypos, VT - 1);
        check("frame_line_done", bus.line_done, 1);
        @(posedge clk); #1;
        check("wrap_x", bus.xpos, 0);
        check("wrap_y", bus.ypos, 0);
        check("wrap_cursor", bus.reset_cursor, AUTO_CURSOR);
        @(posedge clk); #1;
        check("wrap_cursor_end", bus.reset_cursor, 0);

        // Reset during a busy wait: back to sync, cursor pulse, then resume
        bus.lcd_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #2;
        check("rst2_x", bus.xpos, 0);
        check("rst2_cursor", bus.reset_cursor, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 5 && !hit; i++) begin
            @(negedge clk);
            if (bus.reset_cursor) hit = 1'b1;
        end
        check("rst2_cursor_pulse", hit, 1);
        @(posedge clk); #1;
        bus.lcd_busy = 1'b0;
        @(negedge clk);
        check("rst2_pix", bus.pix_clk, 1);
        check("rst2_pix_x", bus.xpos, 0);
        check("rst2_pix_y", bus.ypos, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
